btb_ctrl: RTL and testbench

Update and maintenance controller for the 8-entry branch target buffer in the RV32I pipeline. Accepts resolved-branch reports from EX through a 2-deep queue and decides hit-refresh, allocation or eviction per entry. Owns round-robin replacement and a 2-bit confidence counter per entry. Drives the BTB's single write port and sequences a multi-cycle invalidate-all (flush) walk.

---
 rtl/btb_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_btb_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/btb_ctrl.sv
// Update/maintenance controller for an 8-entry BTB: queues resolved branches,
// keeps shadow tag/valid/confidence state, drives the single write port and runs the flush walk.
module btb_ctrl #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3,
  parameter int QDEPTH  = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             upd_valid_i,
  output logic             upd_ready_o,
  input  logic [31:0]      upd_pc_i,
  input  logic [31:0]      upd_target_i,
  input  logic             upd_taken_i,
  input  logic             flush_req_i,
  output logic             flush_busy_o,
  output logic             wr_en_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic [31:0]      wr_tag_o,
  output logic [31:0]      wr_target_o,
  output logic             wr_valid_o
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_t;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [31:0]        tag_q [ENTRIES];
  logic [31:0]        tag_d [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];
  logic [1:0]         cnt_d [ENTRIES];
  logic [ENTRIES-1:0] valid_q, valid_d;

  upd_t               fifo_q [QDEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  upd_t               head;
  logic               fifo_full, fifo_empty;
  logic               push, pop, fifo_clr;

  logic               hit, free;
  logic [IDX_W-1:0]   hit_idx, free_idx, alloc_idx;
  logic [1:0]         cnt_dec;

  assign head        = fifo_q[rd_ptr_q];
  assign fifo_full   = (count_q == CNT_W'(QDEPTH));
  assign fifo_empty  = (count_q == '0);
  assign upd_ready_o = rst_ni && (state_q == IDLE) && !flush_req_i && !fifo_full;
  assign push        = upd_valid_i && upd_ready_o;

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == head.pc)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign alloc_idx = free ? free_idx : rr_q;
  assign cnt_dec   = cnt_q[hit_idx] - 2'd1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    k_d          = k_q;
    rr_d         = rr_q;
    tag_d        = tag_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    pop          = 1'b0;
    fifo_clr     = 1'b0;
    flush_busy_o = 1'b0;
    wr_en_o      = 1'b0;
    wr_idx_o     = '0;
    wr_tag_o     = head.pc;
    wr_target_o  = head.target;
    wr_valid_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          // Pending head is dropped unwritten; the walk starts next cycle.
          state_d  = CLEAR;
          k_d      = '0;
          fifo_clr = 1'b1;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (hit) begin
            if (head.taken) begin
              wr_en_o        = 1'b1;
              wr_idx_o       = hit_idx;
              wr_valid_o     = 1'b1;
              cnt_d[hit_idx] = (cnt_q[hit_idx] == 2'd3) ? 2'd3 : cnt_q[hit_idx] + 2'd1;
            end else begin
              cnt_d[hit_idx] = cnt_dec;
              if (cnt_dec == 2'd0) begin
                wr_en_o          = 1'b1;
                wr_idx_o         = hit_idx;
                wr_valid_o       = 1'b0;
                valid_d[hit_idx] = 1'b0;
              end
            end
          end else if (head.taken) begin
            wr_en_o            = 1'b1;
            wr_idx_o           = alloc_idx;
            wr_valid_o         = 1'b1;
            tag_d[alloc_idx]   = head.pc;
            valid_d[alloc_idx] = 1'b1;
            cnt_d[alloc_idx]   = 2'b10;
            if (!free) rr_d = rr_q + 1'b1;
          end
        end
      end

      CLEAR: begin
        flush_busy_o = 1'b1;
        wr_en_o      = 1'b1;
        wr_idx_o     = k_q;
        wr_valid_o   = 1'b0;
        k_d          = k_q + 1'b1;
        if (k_q == IDX_W'(ENTRIES - 1)) begin
          state_d = IDLE;
          valid_d = '0;
          rr_d    = '0;
          for (int i = 0; i < ENTRIES; i++) cnt_d[i] = 2'd0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the shadow arrays are reset because lookup trusts valid/cnt right after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      rr_q    <= '0;
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        cnt_q[i] <= 2'd0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q <= state_d;
      k_q     <= k_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (fifo_clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(QDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(QDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Payload storage is qualified by count_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: upd_pc_i, target: upd_target_i, taken: upd_taken_i};
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed bench for btb_ctrl: allocation, confidence, round-robin eviction, flush walk, reset mid-walk.
module tb_btb_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        upd_valid_i;
  logic        upd_ready_o;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_target_i;
  logic        upd_taken_i;
  logic        flush_req_i;
  logic        flush_busy_o;
  logic        wr_en_o;
  logic [2:0]  wr_idx_o;
  logic [31:0] wr_tag_o;
  logic [31:0] wr_target_o;
  logic        wr_valid_o;

  int total = 0;
  int bad   = 0;

  btb_ctrl #(.ENTRIES(8), .IDX_W(3), .QDEPTH(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .upd_valid_i  (upd_valid_i),
    .upd_ready_o  (upd_ready_o),
    .upd_pc_i     (upd_pc_i),
    .upd_target_i (upd_target_i),
    .upd_taken_i  (upd_taken_i),
    .flush_req_i  (flush_req_i),
    .flush_busy_o (flush_busy_o),
    .wr_en_o      (wr_en_o),
    .wr_idx_o     (wr_idx_o),
    .wr_tag_o     (wr_tag_o),
    .wr_target_o  (wr_target_o),
    .wr_valid_o   (wr_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Leaves time 1ns after a rising edge, where outputs are stable.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offers one update, waits (bounded) for acceptance, then drops valid.
  // On return, the cycle after acceptance is current, so the FIFO head is this update when the queue was empty.
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    int n = 0;
    while (!upd_ready_o && n < 20) begin
      step();
      n++;
    end
    if (n == 20) check("ready_timeout", {31'd0, upd_ready_o}, 32'd1);
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_target_i = tgt;
    upd_taken_i  = taken;
    step();
    upd_valid_i  = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [2:0] idx, input logic [31:0] pc,
                              input logic [31:0] tgt, input logic vld);
    check({tag, "_en"}, {31'd0, wr_en_o}, 32'd1);
    check({tag, "_idx"}, {29'd0, wr_idx_o}, {29'd0, idx});
    check({tag, "_valid"}, {31'd0, wr_valid_o}, {31'd0, vld});
    if (vld) begin
      check({tag, "_tag"}, wr_tag_o, pc);
      check({tag, "_target"}, wr_target_o, tgt);
    end
  endtask

  task automatic expect_nowrite(input string tag);
    check({tag, "_en"}, {31'd0, wr_en_o}, 32'd0);
  endtask

  initial begin
    rst_ni       = 1'b0;
    upd_valid_i  = 1'b0;
    upd_pc_i     = '0;
    upd_target_i = '0;
    upd_taken_i  = 1'b0;
    flush_req_i  = 1'b0;
    repeat (3) step();
    check("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
    check("rst_busy", {31'd0, flush_busy_o}, 32'd0);
    check("rst_ready", {31'd0, upd_ready_o}, 32'd0);
    rst_ni = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, upd_ready_o}, 32'd1);
    check("post_rst_wr_en", {31'd0, wr_en_o}, 32'd0);
    step();

    // Allocation, then confidence 2 -> 1 (silent) -> 0 (invalidate) -> miss dropped.
    upd(32'h100, 32'h200, 1'b1);
    expect_write("alloc0", 3'd0, 32'h100, 32'h200, 1'b1);
    upd(32'h100, 32'h200, 1'b0);
    expect_nowrite("nt1");
    upd(32'h100, 32'h200, 1'b0);
    expect_write("nt2", 3'd0, 32'h100, 32'h200, 1'b0);
    upd(32'h100, 32'h200, 1'b0);
    expect_nowrite("nt3");

    // Fill all 8 entries, then round-robin evicts 0 and 1.
    for (int i = 0; i < 10; i++) begin
      upd(32'(i * 4), 32'h1000 + 32'(i), 1'b1);
      expect_write($sformatf("fill%0d", i), (i < 8) ? 3'(i) : 3'(i - 8),
                   32'(i * 4), 32'h1000 + 32'(i), 1'b1);
    end

    // Table full, rr_ptr=2: 0x100 evicts idx 2; hits keep the index and saturate at 3.
    upd(32'h100, 32'h200, 1'b1);
    expect_write("evict2", 3'd2, 32'h100, 32'h200, 1'b1);
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 32'h300, 1'b1);
      expect_write($sformatf("hit%0d", i), 3'd2, 32'h100, 32'h300, 1'b1);
    end
    upd(32'h100, 32'h300, 1'b0);
    expect_nowrite("sat_nt1");
    upd(32'h100, 32'h300, 1'b0);
    expect_nowrite("sat_nt2");
    upd(32'h100, 32'h300, 1'b0);
    expect_write("sat_nt3", 3'd2, 32'h100, 32'h300, 1'b0);
    step();

    // Flush with a queued head and an offered update in the same cycle.
    upd(32'h500, 32'h510, 1'b1);
    upd(32'h600, 32'h610, 1'b1);
    flush_req_i  = 1'b1;
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h650;
    upd_target_i = 32'h660;
    upd_taken_i  = 1'b1;
    #1;
    check("flush_ready", {31'd0, upd_ready_o}, 32'd0);
    check("flush_head_drop", {31'd0, wr_en_o}, 32'd0);
    step();
    flush_req_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("walk%0d_busy", i), {31'd0, flush_busy_o}, 32'd1);
      check($sformatf("walk%0d_ready", i), {31'd0, upd_ready_o}, 32'd0);
      expect_write($sformatf("walk%0d", i), 3'(i), 32'h0, 32'h0, 1'b0);
      step();
    end
    upd_valid_i = 1'b0;
    #1;
    check("walk_end_busy", {31'd0, flush_busy_o}, 32'd0);
    check("walk_end_ready", {31'd0, upd_ready_o}, 32'd1);
    check("walk_end_wr", {31'd0, wr_en_o}, 32'd0);
    upd(32'h700, 32'h800, 1'b1);
    expect_write("post_flush0", 3'd0, 32'h700, 32'h800, 1'b1);
    upd(32'h704, 32'h804, 1'b1);
    expect_write("post_flush1", 3'd1, 32'h704, 32'h804, 1'b1);
    step();

    // Reset in the third cycle of a walk.
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    check("walk_b0_idx", {29'd0, wr_idx_o}, 32'd0);
    step();
    step();
    check("walk_b2_busy", {31'd0, flush_busy_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("midwalk_rst_en", {31'd0, wr_en_o}, 32'd0);
    check("midwalk_rst_busy", {31'd0, flush_busy_o}, 32'd0);
    check("midwalk_rst_ready", {31'd0, upd_ready_o}, 32'd0);
    step();
    step();
    rst_ni = 1'b1;
    #1;
    check("rerst_ready", {31'd0, upd_ready_o}, 32'd1);
    upd(32'h900, 32'h990, 1'b1);
    expect_write("post_rst_alloc", 3'd0, 32'h900, 32'h990, 1'b1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
